uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
Parametrised UART bit-timing generator, successor to the fixed 9600-baud divider. Runtime-programmable divisor, mid-bit sample strobe, end-of-bit strobe, oversample tick and frame bit counting. Sits between UART RX/TX shift FSMs and the system clock. Serves one channel per instance.

Parameters:
DIV_W, 16, width of integer divisor (bit period in clk cycles)
DEFAULT_DIV, 5208, divisor after reset (50 MHz / 9600 baud)
OVERSAMPLE, 16, os_tick pulses per bit period (power of 2, 2..16)
FRAME_BITS, 10, bit periods per frame (start+8 data+stop), 1..15

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  run request from RX/TX FSM; low clears timing
div_wr  in  1  divisor write strobe
div_in  in  DIV_W (DIV_W+4 with FRAC_DIV_EN)  new divisor
div_q  out  DIV_W (DIV_W+4)  active divisor readback
bit_mid  out  1  one-cycle pulse at bit centre (sample point)
bit_end  out  1  one-cycle pulse in last cycle of each bit period
os_tick  out  1  oversample pulse
bit_idx  out  4  index of current bit in frame, 0..FRAME_BITS-1
frame_done  out  1  one-cycle pulse with bit_end of final bit
busy  out  1  en high and counter running

Behaviour:
- Reset: cnt=0, os_cnt=0, bit_idx=0, div_q=DEFAULT_DIV, pending write cleared; bit_mid/bit_end/os_tick/frame_done/busy=0.
- States: IDLE (en=0) and RUN (en=1); no other states. Any cycle with en=0 forces cnt=0, os_cnt=0, bit_idx=0 next edge; all strobes 0 while in IDLE.
- RUN: cnt counts 0..D-1, D = effective divisor; wraps to 0 after D-1 unconditionally. First RUN cycle has cnt=0.
- Strobes are combinational decodes of registered counters, gated by en: bit_mid when cnt==D>>1 (2604 for D=5208); bit_end when cnt==D-1.
- Divisor clamp: D = max(div_q,2); value 0 or 1 behaves as 2.
- div_wr in IDLE: div_q=div_in next edge. div_wr in RUN: captured as pending; applied on the bit_end edge; a later write before then overwrites the pending value. A write coinciding with bit_end is applied at that edge.
- os_tick: os_div = max(D/OVERSAMPLE,1) (floor). os_cnt counts 0..os_div-1; os_tick when os_cnt==os_div-1; os_cnt forced to 0 on bit_end, so ticks realign every bit (last tick of a bit may be short or missing if D not a multiple).
- bit_idx increments on bit_end; at FRAME_BITS-1 wraps to 0 and frame_done pulses in the same cycle as that bit_end. Continuous en runs back-to-back frames.
- en dropped mid-bit: period aborted, no strobes, no frame_done; next en restarts at cnt=0, bit_idx=0.
- busy = en; registered status not required.
- Reset mid-operation: immediate return to reset values, including div_q=DEFAULT_DIV.

Optional Feature:
FRAC_DIV_EN. Defined: div_in/div_q gain 4 fractional LSBs; 4-bit frac_acc adds the fraction at each bit_end; carry-out lengthens the next bit period to int+1 cycles; frac_acc cleared in IDLE and by reset; DEFAULT_DIV is shifted left 4. Undefined: integer divisor only, no accumulator, port widths DIV_W.

Decomposition:
- Package uart_pkg: FRAC_W=4, DIV_MIN=2, BIT_IDX_W=4, CLK_HZ constant, DEFAULT_DIV/baud helper function.
- One sub-module natural: uart_frac_acc (fractional accumulator + period-extend flag), only instantiated under FRAC_DIV_EN.

Test Plan:
- Reset, en=1, default divisor -> bit_mid at cnt 2604, bit_end at 5207, period exactly 5208 cycles, div_q=5208.
- IDLE write div_in=10, en=1 for 100 cycles -> bit_mid at cycles 5,15,...,95; bit_end at 9,19,...,99; frame_done only at 99; bit_idx 0..9 then 0.
- div_in=32, OVERSAMPLE=16 -> os_tick every 2 cycles, 16 per bit, first at cycle 1; div_in=35 -> os_div=2, os_cnt reset on bit_end, 17 ticks per bit.
- RUN with div=10, write div_in=20 at cycle 3 -> first period 10 cycles, next periods 20; second write before bit_end wins.
- en low at cycle 7 of bit 4 -> no strobes; re-enable -> bit_idx=0, bit_mid 5 cycles later; div_in=0 -> period 2 cycles, bit_mid and bit_end both at cnt 1.
- FRAC_DIV_EN, div_in=10.5 (0xA8) -> periods alternate 10,11; 16 bits total 168 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART bit-timing generator.
// Optional build macro FRAC_DIV_EN adds 4 fractional divisor bits.
package uart_pkg;

  localparam int unsigned FRAC_W    = 4;
  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned BIT_IDX_W = 4;
  localparam int unsigned CLK_HZ    = 50_000_000;

`ifdef FRAC_DIV_EN
  localparam int unsigned DIV_FRAC_BITS = FRAC_W;
`else
  localparam int unsigned DIV_FRAC_BITS = 0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Integer bit period in clk cycles for a baud rate, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional divisor accumulator: the carry out of acc+frac stretches the
// bit period currently being timed by one clk; acc advances at bit_end.
// Only present in builds with FRAC_DIV_EN defined.
`ifdef FRAC_DIV_EN
module uart_frac_acc
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              extend
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  // Next accumulator value and its carry (the period-extend flag).
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, frac};
    extend = sum[FRAC_W];
  end

  // Accumulate once per bit period; cleared whenever the channel is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule
`endif

// File: rtl/uart_baud_gen.sv
// UART bit-timing generator: programmable divisor, mid-bit sample strobe,
// end-of-bit strobe, oversample tick and frame bit index.
// Build macro FRAC_DIV_EN: divisor gains 4 fractional LSBs (uart_frac_acc).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = baud_div(CLK_HZ, 9600),
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FRAME_BITS  = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            div_wr,
  input  logic [DIV_W+DIV_FRAC_BITS-1:0]  div_in,
  output logic [DIV_W+DIV_FRAC_BITS-1:0]  div_q,
  output logic                            bit_mid,
  output logic                            bit_end,
  output logic                            os_tick,
  output logic [BIT_IDX_W-1:0]            bit_idx,
  output logic                            frame_done,
  output logic                            busy
);

  localparam int unsigned Q_W   = DIV_W + DIV_FRAC_BITS;
  localparam int unsigned D_W   = DIV_W + 1;
  localparam int unsigned OS_SH = $clog2(OVERSAMPLE);
  localparam logic [Q_W-1:0] RST_DIV = Q_W'(DEFAULT_DIV) << DIV_FRAC_BITS;

  state_e             state;
  logic               idle;
  logic               extend;
  logic [Q_W-1:0]     pend_div;
  logic               pend_vld;
  logic [DIV_W-1:0]   div_int;
  logic [D_W-1:0]     base_div;
  logic [D_W-1:0]     eff_div;
  logic [D_W-1:0]     half_div;
  logic [D_W-1:0]     last_div;
  logic [D_W-1:0]     os_div;
  logic [D_W-1:0]     os_last;
  logic [DIV_W-1:0]   cnt;
  logic [D_W-1:0]     os_cnt;

  // Operating mode follows the run request directly.
  always_comb begin
    state = en ? RUN : IDLE;
    idle  = (state == IDLE);
  end

`ifdef FRAC_DIV_EN
  uart_frac_acc u_frac_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (idle),
    .step   (bit_end),
    .frac   (div_q[FRAC_W-1:0]),
    .extend (extend)
  );
`else
  assign extend = 1'b0;
`endif

  // Effective bit period (clamped to DIV_MIN) and derived decode points.
  always_comb begin
    div_int  = div_q[Q_W-1 -: DIV_W];
    base_div = (div_int < DIV_W'(DIV_MIN)) ? D_W'(DIV_MIN) : {1'b0, div_int};
    eff_div  = base_div + D_W'(extend);
    half_div = eff_div >> 1;
    last_div = eff_div - D_W'(1);
    os_div   = eff_div >> OS_SH;
    if (os_div == '0) begin
      os_div = D_W'(1);
    end
    os_last  = os_div - D_W'(1);
  end

  // Strobes decoded from the registered counters, silent while idle.
  always_comb begin
    bit_mid    = (state == RUN) && ({1'b0, cnt} == half_div);
    bit_end    = (state == RUN) && ({1'b0, cnt} == last_div);
    os_tick    = (state == RUN) && (os_cnt == os_last);
    frame_done = bit_end && (bit_idx == BIT_IDX_W'(FRAME_BITS - 1));
    busy       = (state == RUN);
  end

  // Bit, oversample and frame counters; idle holds them at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      os_cnt  <= '0;
      bit_idx <= '0;
    end else if (idle) begin
      cnt     <= '0;
      os_cnt  <= '0;
      bit_idx <= '0;
    end else begin
      cnt <= bit_end ? '0 : cnt + DIV_W'(1);
      if (bit_end || os_tick) begin
        os_cnt <= '0;
      end else begin
        os_cnt <= os_cnt + D_W'(1);
      end
      if (bit_end) begin
        bit_idx <= frame_done ? '0 : bit_idx + BIT_IDX_W'(1);
      end
    end
  end

  // Divisor register: immediate when idle, deferred to bit_end while running.
  // A write still pending when the channel goes idle is committed there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= RST_DIV;
      pend_div <= '0;
      pend_vld <= 1'b0;
    end else if (idle || bit_end) begin
      if (div_wr) begin
        div_q <= div_in;
      end else if (pend_vld) begin
        div_q <= pend_div;
      end
      pend_vld <= 1'b0;
    end else if (div_wr) begin
      pend_div <= div_in;
      pend_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: table of divisor scenarios plus
// hand-written sequences for divisor updates, en drop and reset.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned Q_W   = DIV_W + DIV_FRAC_BITS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           div_wr;
  logic [Q_W-1:0] div_in;
  logic [Q_W-1:0] div_q;
  logic           bit_mid;
  logic           bit_end;
  logic           os_tick;
  logic [3:0]     bit_idx;
  logic           frame_done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_baud_gen #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (5208),
    .OVERSAMPLE  (16),
    .FRAME_BITS  (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_wr     (div_wr),
    .div_in     (div_in),
    .div_q      (div_q),
    .bit_mid    (bit_mid),
    .bit_end    (bit_end),
    .os_tick    (os_tick),
    .bit_idx    (bit_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  typedef struct {
    int div;
    int cycles;
    int n_mid;
    int n_end;
    int n_os;
    int n_frame;
    int first_mid;
    int first_end;
    int first_os;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [Q_W-1:0] mk(input int unsigned v);
    return Q_W'(v) << DIV_FRAC_BITS;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with a divisor write; leaves en low, counters cleared.
  task automatic set_div(input logic [Q_W-1:0] v);
    en     = 1'b0;
    div_wr = 1'b1;
    div_in = v;
    next();
    div_wr = 1'b0;
  endtask

  initial begin
    int n_mid, n_end, n_os, n_frame, f_mid, f_end, f_os, merr;
    int ends[$];

    vecs[0] = '{10, 100, 10, 10, 100, 1,  5,  9, 0};
    vecs[1] = '{32,  32,  1,  1,  16, 0, 16, 31, 1};
    vecs[2] = '{35,  35,  1,  1,  17, 0, 17, 34, 1};
    vecs[3] = '{ 0,  10,  5,  5,  10, 0,  1,  1, 0};
    vecs[4] = '{ 1,  20, 10, 10,  20, 1,  1,  1, 0};
    vecs[5] = '{ 7,  14,  2,  2,  14, 0,  3,  6, 0};
    vecs[6] = '{48,  48,  1,  1,  16, 0, 24, 47, 2};

    // Reset values
    rst_n = 1'b0; en = 1'b0; div_wr = 1'b0; div_in = '0;
    #2;
    next();
    check("rst_div_q", div_q, mk(5208));
    check("rst_strobes", {bit_mid, bit_end, os_tick, frame_done, busy}, 0);
    check("rst_bit_idx", bit_idx, 0);
    rst_n = 1'b1;
    next();

    // Default divisor: two full bit periods
    en = 1'b1;
    n_mid = 0; f_mid = -1; ends.delete();
    for (int k = 0; k < 10416; k++) begin
      #2;
      if (bit_mid) begin n_mid++; if (f_mid < 0) f_mid = k; end
      if (bit_end) ends.push_back(k);
      next();
    end
    #2;
    check("def_first_mid", f_mid, 2604);
    check("def_n_mid", n_mid, 2);
    check("def_n_end", ends.size(), 2);
    if (ends.size() == 2) begin
      check("def_end0", ends[0], 5207);
      check("def_end1", ends[1], 10415);
    end
    check("def_bit_idx", bit_idx, 2);
    check("def_busy", busy, 1);

    // Table of divisor scenarios with a per-cycle reference model
    foreach (vecs[i]) begin
      set_div(mk(vecs[i].div));
      check($sformatf("v%0d_div_q", i), div_q, mk(vecs[i].div));
      en = 1'b1;
      n_mid = 0; n_end = 0; n_os = 0; n_frame = 0;
      f_mid = -1; f_end = -1; f_os = -1; merr = 0;
      for (int k = 0; k < vecs[i].cycles; k++) begin
        int dm, c, osd;
        logic [3:0] ei;
        logic em, ee, eo, ef;
        #2;
        dm  = (vecs[i].div < 2) ? 2 : vecs[i].div;
        c   = k % dm;
        osd = dm / 16;
        if (osd == 0) osd = 1;
        em  = (c == dm / 2);
        ee  = (c == dm - 1);
        eo  = ((c % osd) == osd - 1);
        ei  = 4'((k / dm) % 10);
        ef  = ee && (ei == 4'd9);
        if ({bit_mid, bit_end, os_tick, frame_done, bit_idx} !== {em, ee, eo, ef, ei}) merr++;
        if (bit_mid) begin n_mid++; if (f_mid < 0) f_mid = k; end
        if (bit_end) begin n_end++; if (f_end < 0) f_end = k; end
        if (os_tick) begin n_os++;  if (f_os  < 0) f_os  = k; end
        if (frame_done) n_frame++;
        next();
      end
      en = 1'b0;
      check($sformatf("v%0d_trace", i), merr, 0);
      check($sformatf("v%0d_n_mid", i), n_mid, vecs[i].n_mid);
      check($sformatf("v%0d_n_end", i), n_end, vecs[i].n_end);
      check($sformatf("v%0d_n_os", i), n_os, vecs[i].n_os);
      check($sformatf("v%0d_n_frame", i), n_frame, vecs[i].n_frame);
      check($sformatf("v%0d_first_mid", i), f_mid, vecs[i].first_mid);
      check($sformatf("v%0d_first_end", i), f_end, vecs[i].first_end);
      check($sformatf("v%0d_first_os", i), f_os, vecs[i].first_os);
    end

    // Divisor writes while running: pending overwrite, write on bit_end
    set_div(mk(10));
    en = 1'b1;
    ends.delete();
    for (int k = 0; k < 62; k++) begin
      div_wr = 1'b0;
      if (k == 3)  begin div_wr = 1'b1; div_in = mk(40); end
      if (k == 6)  begin div_wr = 1'b1; div_in = mk(20); end
      if (k == 49) begin div_wr = 1'b1; div_in = mk(12); end
      #2;
      if (k == 8)  check("wr_pending_held", div_q, mk(10));
      if (k == 10) check("wr_applied", div_q, mk(20));
      if (k == 50) check("wr_on_end", div_q, mk(12));
      if (bit_end) ends.push_back(k);
      next();
    end
    div_wr = 1'b0;
    check("wr_n_end", ends.size(), 4);
    if (ends.size() == 4) begin
      check("wr_end0", ends[0], 9);
      check("wr_end1", ends[1], 29);
      check("wr_end2", ends[2], 49);
      check("wr_end3", ends[3], 61);
    end

    // en dropped at cycle 7 of bit 4, then restart
    set_div(mk(10));
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k == 47) en = 1'b0;
      #2;
      if (k == 46) check("drop_idx_before", bit_idx, 4);
      if (k >= 47) check($sformatf("drop_quiet_%0d", k),
                         {bit_mid, bit_end, os_tick, frame_done, busy}, 0);
      next();
    end
    en = 1'b1;
    f_mid = -1; f_end = -1; n_frame = 0;
    for (int r = 0; r < 20; r++) begin
      #2;
      if (r == 0)  check("restart_idx", bit_idx, 0);
      if (r == 10) check("restart_idx_after", bit_idx, 1);
      if (bit_mid && f_mid < 0) f_mid = r;
      if (bit_end && f_end < 0) f_end = r;
      if (frame_done) n_frame++;
      next();
    end
    check("restart_first_mid", f_mid, 5);
    check("restart_first_end", f_end, 9);
    check("restart_no_frame", n_frame, 0);

    // Asynchronous reset in the middle of a run
    set_div(mk(10));
    en = 1'b1;
    for (int k = 0; k < 13; k++) next();
    #2;
    check("pre_rst_idx", bit_idx, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_div_q", div_q, mk(5208));
    check("midrst_idx", bit_idx, 0);
    check("midrst_strobes", {bit_mid, bit_end, os_tick, frame_done}, 0);
    en = 1'b0;
    next();
    rst_n = 1'b1;
    next();

`ifdef FRAC_DIV_EN
    // 10.5 cycles per bit: periods 10,11,10,11,...
    set_div(Q_W'(8'hA8));
    en = 1'b1;
    ends.delete();
    for (int k = 0; k < 168; k++) begin
      #2;
      if (bit_end) ends.push_back(k);
      next();
    end
    en = 1'b0;
    check("frac_n_end", ends.size(), 16);
    if (ends.size() == 16) begin
      check("frac_end0", ends[0], 9);
      check("frac_end1", ends[1], 20);
      check("frac_end15", ends[15], 167);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
